// File: rtl/spi_request_arbiter_if.sv
// Stream bundle between two requesters, the SPI master byte streams and the arbiter.
// The arbiter uses the master modport; client/SPI-side models use the slave modport.
interface spi_request_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             s0_tvalid, s0_tready, s0_tlast;
  logic [WIDTH-1:0] s0_tdata;
  logic             s1_tvalid, s1_tready, s1_tlast;
  logic [WIDTH-1:0] s1_tdata;
  logic             x_tvalid, x_tready, x_tlast;
  logic [WIDTH-1:0] x_tdata;
  logic             y_tvalid, y_tready, y_tlast;
  logic [WIDTH-1:0] y_tdata;
  logic             m0_tvalid, m0_tready, m0_tlast;
  logic [WIDTH-1:0] m0_tdata;
  logic             m1_tvalid, m1_tready, m1_tlast;
  logic [WIDTH-1:0] m1_tdata;

  modport master (
    input  s0_tvalid, s0_tlast, s0_tdata, output s0_tready,
    input  s1_tvalid, s1_tlast, s1_tdata, output s1_tready,
    output x_tvalid, x_tlast, x_tdata,    input  x_tready,
    input  y_tvalid, y_tlast, y_tdata,    output y_tready,
    output m0_tvalid, m0_tlast, m0_tdata, input  m0_tready,
    output m1_tvalid, m1_tlast, m1_tdata, input  m1_tready
  );

  modport slave (
    output s0_tvalid, s0_tlast, s0_tdata, input  s0_tready,
    output s1_tvalid, s1_tlast, s1_tdata, input  s1_tready,
    input  x_tvalid, x_tlast, x_tdata,    output x_tready,
    output y_tvalid, y_tlast, y_tdata,    input  y_tready,
    input  m0_tvalid, m0_tlast, m0_tdata, output m0_tready,
    input  m1_tvalid, m1_tlast, m1_tdata, output m1_tready
  );
endinterface

// File: rtl/spi_request_arbiter.sv
// Round-robin sharing of one SPI master byte stream between two requesters,
// with transaction-boundary arbitration, response routing, idle gap and response timeout.
module spi_request_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 4,
  parameter int TBITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  spi_request_arbiter_if.master bus,
  output logic [1:0]            grant_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic                  drop_o
);
  localparam int NUM_REQ = 2;
  // Timeout fires on the cycle the counter would step from all-ones-minus-one to all-ones.
  localparam logic [TBITS-1:0] TLIM   = TBITS'((64'd1 << TBITS) - 64'd2);
  localparam logic [7:0]       GAP_LD = 8'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

  state_t           state;
  logic             prio, rdone;
  logic [7:0]       gcnt;
  logic [TBITS-1:0] tcnt;

  logic [NUM_REQ-1:0]            s_vld, s_lst, s_rdy, m_rdy, m_vld;
  logic [NUM_REQ-1:0][WIDTH-1:0] s_dat;
  logic sending, active, win, sel;
  logic x_acc, x_done, y_acc, y_done;

  assign s_vld = {bus.s1_tvalid, bus.s0_tvalid};
  assign s_lst = {bus.s1_tlast,  bus.s0_tlast};
  assign s_dat = {bus.s1_tdata,  bus.s0_tdata};
  assign m_rdy = {bus.m1_tready, bus.m0_tready};

  // Reset gates every combinational handshake so a mid-transaction reset drops them at once.
  assign sending = !reset && (state == S_SEND);
  assign active  = !reset && (state == S_SEND || state == S_WAIT);
  assign sel     = grant_o[1];
  assign win     = (&s_vld) ? prio : s_vld[1];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign s_rdy[i] = sending && grant_o[i] && bus.x_tready;
      assign m_vld[i] = active && grant_o[i] && bus.y_tvalid;
    end
  endgenerate

  assign bus.s0_tready = s_rdy[0];
  assign bus.s1_tready = s_rdy[1];

  assign bus.x_tvalid = sending && |(grant_o & s_vld);
  assign bus.x_tdata  = s_dat[sel];
  assign bus.x_tlast  = s_lst[sel];

  // Outside a transaction the response side is drained so stale beats never stall the SPI master.
  assign bus.y_tready = reset ? 1'b0 : (active ? |(grant_o & m_rdy) : 1'b1);

  assign bus.m0_tvalid = m_vld[0];
  assign bus.m0_tdata  = bus.y_tdata;
  assign bus.m0_tlast  = bus.y_tlast;
  assign bus.m1_tvalid = m_vld[1];
  assign bus.m1_tdata  = bus.y_tdata;
  assign bus.m1_tlast  = bus.y_tlast;

  assign x_acc  = bus.x_tvalid && bus.x_tready;
  assign x_done = x_acc && bus.x_tlast;
  assign y_acc  = bus.y_tvalid && bus.y_tready;
  assign y_done = active && y_acc && bus.y_tlast;

  assign drop_o = y_acc && !active;
  assign busy_o = active;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      grant_o   <= '0;
      prio      <= 1'b0;
      rdone     <= 1'b0;
      gcnt      <= '0;
      tcnt      <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|s_vld) begin
            grant_o <= win ? 2'b10 : 2'b01;
            prio    <= !win;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (y_done) rdone <= 1'b1;
          if (x_done) begin
            if (rdone || y_done) begin
              state   <= S_GAP;
              grant_o <= '0;
              rdone   <= 1'b0;
              gcnt    <= GAP_LD;
            end else begin
              state <= S_WAIT;
              tcnt  <= '0;
            end
          end
        end
        S_WAIT: begin
          if (rdone || y_done) begin
            state   <= S_GAP;
            grant_o <= '0;
            rdone   <= 1'b0;
            gcnt    <= GAP_LD;
          end else if (y_acc) begin
            tcnt <= '0;
          end else if (tcnt == TLIM) begin
            // Response abandoned; any late beats are drained as drops.
            timeout_o <= 1'b1;
            state     <= S_GAP;
            grant_o   <= '0;
            rdone     <= 1'b0;
            gcnt      <= GAP_LD;
          end else begin
            tcnt <= tcnt + TBITS'(1);
          end
        end
        S_GAP: begin
          grant_o <= '0;
          rdone   <= 1'b0;
          // GAP=0 and GAP=1 both spend a single cycle here.
          if (gcnt <= 8'd1) state <= S_IDLE;
          else              gcnt  <= gcnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed and randomized checks of spi_request_arbiter against a packet-level
// round-robin model with a byte-inverting SPI loopback.
module tb_spi_request_arbiter;
  localparam int GAPC = 4;
  localparam int TB   = 4;

  typedef logic [8:0] beat_q_t[$];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant_o;
  logic       busy_o, timeout_o, drop_o;

  spi_request_arbiter_if #(.WIDTH(8)) bus();

  spi_request_arbiter #(.WIDTH(8), .GAP(GAPC), .TBITS(TB)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o), .drop_o(drop_o)
  );

  always #5 clock = ~clock;

  logic [8:0] req_q0[$], req_q1[$], y_q[$], mq0[$], mq1[$];
  logic [8:0] x_log[$], m0_log[$], m1_log[$], gseq[$];
  logic [8:0] exp_x[$], exp_m0[$], exp_m1[$], exp_g[$];
  int gap_runs[$];
  int checks = 0, failures = 0;
  int cyc = 0, zrun = 0, g11 = 0, badr = 0;
  int tv_cyc, g_cyc, xv_cyc, xlast_cyc, tout_cyc, busy_cnt, drops, touts, m0v;
  logic [1:0] prev_g = 2'b00;
  bit mprio = 1'b0;
  bit loop_en = 1'b1, y_gate = 1'b0, rnd = 1'b0;
  int xmode = 0, m0_hold = 0, hold_at = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input beat_q_t got, input beat_q_t exp);
    int bad = -1;
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    chk({tag, "_first_bad_idx"}, bad, -1);
  endtask

  task automatic add_beat(input int r, input logic [7:0] d, input logic l);
    if (r == 0) begin req_q0.push_back({l, d}); mq0.push_back({l, d}); end
    else        begin req_q1.push_back({l, d}); mq1.push_back({l, d}); end
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int i = 0; i < len; i++) add_beat(r, 8'($urandom_range(0, 255)), i == len - 1);
  endtask

  // Packet-level reference: round-robin over pending packets, responses are inverted echoes.
  task automatic model(input bit lp);
    while (mq0.size() > 0 || mq1.size() > 0) begin
      bit w;
      logic [8:0] b;
      if (mq0.size() > 0 && mq1.size() > 0) w = mprio;
      else w = (mq1.size() > 0);
      mprio = !w;
      exp_g.push_back(w ? 9'd2 : 9'd1);
      do begin
        if (w) b = mq1.pop_front(); else b = mq0.pop_front();
        exp_x.push_back(b);
        if (lp) begin
          if (w) exp_m1.push_back({b[8], ~b[7:0]});
          else   exp_m0.push_back({b[8], ~b[7:0]});
        end
      end while (!b[8] && (w ? mq1.size() : mq0.size()) > 0);
    end
  endtask

  task automatic drive();
    bus.s0_tvalid = req_q0.size() > 0;
    {bus.s0_tlast, bus.s0_tdata} = 9'h000;
    if (req_q0.size() > 0) {bus.s0_tlast, bus.s0_tdata} = req_q0[0];
    bus.s1_tvalid = req_q1.size() > 0;
    {bus.s1_tlast, bus.s1_tdata} = 9'h000;
    if (req_q1.size() > 0) {bus.s1_tlast, bus.s1_tdata} = req_q1[0];
    case (xmode)
      0:       bus.x_tready = 1'b1;
      1:       bus.x_tready = !bus.x_tready;
      default: bus.x_tready = ($urandom_range(0, 3) != 0);
    endcase
    if (hold_at >= 0 && m0_log.size() >= hold_at) begin m0_hold = 5; hold_at = -1; end
    if (m0_hold > 0) begin bus.m0_tready = 1'b0; m0_hold--; end
    else bus.m0_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.m1_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.y_tvalid = (y_q.size() > 0) && (!y_gate || grant_o != 2'b00) &&
                   (!rnd || $urandom_range(0, 3) != 0);
    {bus.y_tlast, bus.y_tdata} = 9'h000;
    if (y_q.size() > 0) {bus.y_tlast, bus.y_tdata} = y_q[0];
  endtask

  task automatic sample();
    cyc++;
    if (bus.s0_tvalid && bus.s0_tready && req_q0.size() > 0) void'(req_q0.pop_front());
    if (bus.s1_tvalid && bus.s1_tready && req_q1.size() > 0) void'(req_q1.pop_front());
    if (bus.y_tvalid && bus.y_tready && y_q.size() > 0) void'(y_q.pop_front());
    if (bus.x_tvalid && bus.x_tready) begin
      x_log.push_back({bus.x_tlast, bus.x_tdata});
      if (loop_en) y_q.push_back({bus.x_tlast, ~bus.x_tdata});
      if (bus.x_tlast) xlast_cyc = cyc;
    end
    if (bus.m0_tvalid && bus.m0_tready) m0_log.push_back({bus.m0_tlast, bus.m0_tdata});
    if (bus.m1_tvalid && bus.m1_tready) m1_log.push_back({bus.m1_tlast, bus.m1_tdata});
    if (drop_o) drops++;
    if (timeout_o) begin touts++; if (tout_cyc < 0) tout_cyc = cyc; end
    if (busy_o) busy_cnt++;
    if (bus.m0_tvalid) m0v++;
    if (grant_o == 2'b11) g11++;
    if (bus.m0_tvalid && grant_o != 2'b01) badr++;
    if (bus.m1_tvalid && grant_o != 2'b10) badr++;
    if (bus.s0_tvalid && tv_cyc < 0) tv_cyc = cyc;
    if (bus.x_tvalid && xv_cyc < 0) xv_cyc = cyc;
    if (grant_o != 2'b00 && prev_g == 2'b00) begin
      gseq.push_back({7'd0, grant_o});
      gap_runs.push_back(zrun);
      if (g_cyc < 0) g_cyc = cyc;
    end
    zrun   = (grant_o == 2'b00) ? zrun + 1 : 0;
    prev_g = grant_o;
  endtask

  task automatic tick();
    @(posedge clock); #1;
    drive();
    @(negedge clock);
    sample();
  endtask

  task automatic clear_phase();
    x_log.delete(); m0_log.delete(); m1_log.delete(); gseq.delete(); gap_runs.delete();
    exp_x.delete(); exp_m0.delete(); exp_m1.delete(); exp_g.delete();
    tv_cyc = -1; g_cyc = -1; xv_cyc = -1; xlast_cyc = -1; tout_cyc = -1;
    busy_cnt = 0; drops = 0; touts = 0; m0v = 0;
  endtask

  task automatic run_idle(input string tag, input int maxc);
    int n = 0;
    do begin tick(); n++; end
    while (!(req_q0.size() == 0 && req_q1.size() == 0 && y_q.size() == 0 &&
             !busy_o && grant_o == 2'b00) && n < maxc);
    chk({tag, "_done_in_budget"}, n < maxc, 1);
    repeat (GAPC + 3) tick();
  endtask

  task automatic check_streams(input string tag);
    chk_q({tag, "_x"}, x_log, exp_x);
    chk_q({tag, "_m0"}, m0_log, exp_m0);
    chk_q({tag, "_m1"}, m1_log, exp_m1);
    chk_q({tag, "_grants"}, gseq, exp_g);
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < gap_runs.size(); i++) chk({tag, "_gap_run"}, gap_runs[i], GAPC + 1);
  endtask

  initial begin
    bus.s0_tvalid = 0; bus.s0_tlast = 0; bus.s0_tdata = 0;
    bus.s1_tvalid = 0; bus.s1_tlast = 0; bus.s1_tdata = 0;
    bus.x_tready = 0; bus.y_tvalid = 0; bus.y_tlast = 0; bus.y_tdata = 0;
    bus.m0_tready = 0; bus.m1_tready = 0;
    clear_phase();

    // Reset state
    repeat (3) tick();
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_tready", {bus.s0_tready, bus.s1_tready, bus.y_tready}, 3'b000);
    chk("rst_tvalid", {bus.x_tvalid, bus.m0_tvalid, bus.m1_tvalid}, 3'b000);

    // Contention from reset: s0,s1,s0,s1
    clear_phase();
    for (int k = 0; k < 2; k++) begin add_pkt(0, 2); add_pkt(1, 2); end
    tick();
    chk("rst_hold_tready", {bus.s0_tready, bus.s1_tready}, 2'b00);
    reset = 1'b0;
    run_idle("contention", 400);
    model(1'b1);
    check_streams("contention");
    chk("contention_gap_count", gap_runs.size(), 4);
    check_gaps("contention");

    // Single request A5,5A,FF
    clear_phase();
    add_beat(0, 8'hA5, 0); add_beat(0, 8'h5A, 0); add_beat(0, 8'hFF, 1);
    run_idle("single", 200);
    model(1'b1);
    check_streams("single");
    chk("single_grant_latency", g_cyc - tv_cyc, 1);
    chk("single_xvalid_latency", xv_cyc - tv_cyc, 1);
    chk("single_drops", drops, 0);

    // Back-pressure: toggling x_tready, m0_tready low 5 cycles mid-response
    clear_phase();
    add_pkt(0, 6);
    xmode = 1; hold_at = 2;
    run_idle("bp", 400);
    xmode = 0;
    model(1'b1);
    check_streams("bp");
    chk("bp_timeouts", touts, 0);

    // Timeout with silent response, then a late stale beat
    clear_phase();
    loop_en = 1'b0;
    add_beat(0, 8'h3E, 1);
    run_idle("tmo", 200);
    model(1'b0);
    check_streams("tmo");
    chk("tmo_pulses", touts, 1);
    chk("tmo_delay", tout_cyc - xlast_cyc, 16);
    chk("tmo_busy_cycles", busy_cnt, 16);
    y_q.push_back(9'h177);
    run_idle("tmo_late", 50);
    chk("tmo_late_drops", drops, 1);
    chk("tmo_late_m0valid", m0v, 0);
    chk("tmo_late_m0beats", m0_log.size(), 0);

    // Early response: y_tlast and x_tlast in the same SEND cycle
    clear_phase();
    y_gate = 1'b1;
    add_beat(0, 8'h42, 1);
    y_q.push_back(9'h13C);
    run_idle("early", 200);
    y_gate = 1'b0; loop_en = 1'b1;
    model(1'b0);
    exp_m0.push_back(9'h13C);
    check_streams("early");
    chk("early_busy_cycles", busy_cnt, 1);
    chk("early_timeouts", touts, 0);
    chk("early_drops", drops, 0);

    // Reset after 1 of 3 request bytes
    clear_phase();
    add_beat(0, 8'h11, 0); add_beat(0, 8'h22, 0); add_beat(0, 8'h33, 1);
    begin
      int n = 0;
      do begin tick(); n++; end while (x_log.size() < 1 && n < 50);
      chk("midrst_first_beat_budget", n < 50, 1);
    end
    chk("midrst_first_beat", x_log.size() > 0 ? x_log[0] : 9'h000, 9'h011);
    @(posedge clock); #1;
    reset = 1'b1;
    drive();
    @(negedge clock); sample();
    chk("midrst_during_tready", {bus.s0_tready, bus.s1_tready, bus.y_tready}, 3'b000);
    chk("midrst_during_xvalid", bus.x_tvalid, 0);
    req_q0.delete(); mq0.delete(); y_q.delete(); mprio = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    drive();
    @(negedge clock); sample();
    chk("midrst_grant", grant_o, 2'b00);
    chk("midrst_tready", {bus.s0_tready, bus.s1_tready}, 2'b00);
    chk("midrst_busy", busy_o, 0);
    clear_phase();
    add_pkt(1, 2); add_pkt(0, 2);
    run_idle("postrst", 300);
    model(1'b1);
    check_streams("postrst");

    // Randomized rounds with random throttling on every stream
    rnd = 1'b1; xmode = 2;
    for (int r = 0; r < 3; r++) begin
      clear_phase();
      for (int k = $urandom_range(1, 4); k > 0; k--) add_pkt(0, $urandom_range(1, 4));
      for (int k = $urandom_range(1, 4); k > 0; k--) add_pkt(1, $urandom_range(1, 4));
      run_idle("rand", 3000);
      model(1'b1);
      check_streams("rand");
      check_gaps("rand");
      chk("rand_timeouts", touts, 0);
      chk("rand_drops", drops, 0);
    end

    chk("grant_never_11", g11, 0);
    chk("response_routing", badr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_request_arbiter.md
Name: spi_request_arbiter

Overview:
- Shares one SPI master's byte-stream interface between two AXI-Stream requesters.
- Arbitration is round-robin and happens only at transaction boundaries. A transaction is one request packet, terminated by tlast, plus its full-duplex response packet.
- Response bytes are routed back to the requester that owns the current grant.
- The block enforces a minimum idle gap between transactions and a response timeout.
- It sits in the master-side clock domain, between the client logic and spi_master or its TX/RX FIFOs.

Parameters:
- WIDTH, 8, data width of every stream.
- GAP, 4, idle clock cycles between the end of one transaction and the next grant. Range 0..255.
- TBITS, 10, width of the response-timeout counter. Timeout occurs after 2^TBITS-1 cycles in WAIT.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s0_tvalid/s0_tready/s0_tlast  in/out/in  1  requester 0 request stream.
- s0_tdata  in  WIDTH  requester 0 request data.
- s1_tvalid/s1_tready/s1_tlast  in/out/in  1  requester 1 request stream.
- s1_tdata  in  WIDTH  requester 1 request data.
- x_tvalid/x_tready/x_tlast  out/in/out  1  request stream to the SPI master.
- x_tdata  out  WIDTH  request data to the SPI master.
- y_tvalid/y_tready/y_tlast  in/out/in  1  response stream from the SPI master.
- y_tdata  in  WIDTH  response data from the SPI master.
- m0_tvalid/m0_tready/m0_tlast  out/in/out  1  response stream to requester 0.
- m0_tdata  out  WIDTH  response data to requester 0.
- m1_tvalid/m1_tready/m1_tlast  out/in/out  1  response stream to requester 1.
- m1_tdata  out  WIDTH  response data to requester 1.
- grant_o  out  2  one-hot grant. 00 when no transaction is active.
- busy_o  out  1  high in SEND or WAIT.
- timeout_o  out  1  one-cycle pulse when a transaction is aborted by timeout.
- drop_o  out  1  one-cycle pulse for each response beat discarded while no requester is granted.

Behaviour:

Reset:
- state=IDLE, grant=00, prio=0 (requester 0 first), rdone=0, gap counter=0, timeout counter=0.
- All tvalid/tready outputs, timeout_o and drop_o are 0.

IDLE:
- If any sN_tvalid is high, grant it on the next clock edge and go to SEND.
- If both are high, the requester selected by prio wins, and prio is set to the loser.
- If exactly one is high, it wins, and prio is set to the other requester.
- Latency from sN_tvalid to the first x_tvalid is one cycle.
- No tready is asserted in IDLE.

SEND:
- x_* is combinationally driven from the granted sN_*. The granted sN_tready equals x_tready. The other requester's tready is 0.
- On a request beat with x_tlast accepted:
  - if rdone=1, go to GAP;
  - otherwise go to WAIT with the timeout counter cleared.

SEND and WAIT response routing:
- y_* is routed combinationally to the granted mN_*, and y_tready equals the granted mN_tready.
- The ungranted m_tvalid is 0.
- An accepted y_tlast beat sets rdone.
- In WAIT, rdone being set or an accepted y_tlast moves the block to GAP.

WAIT timeout:
- The timeout counter increments every cycle in which no y beat is accepted, and clears whenever a y beat is accepted.
- When the counter reaches all-ones: pulse timeout_o, go to GAP, leave the response unfinished.

GAP:
- grant=00, rdone cleared, x_tvalid=0.
- The block waits GAP cycles (counter loaded with GAP on entry), then returns to IDLE.
- With GAP=0 the block stays in GAP for exactly one cycle.

Outside SEND/WAIT:
- y_tready=1. Every accepted y beat is discarded and pulses drop_o.
- This covers stale responses after a timeout.

Simultaneous events:
- A request tlast and a response tlast accepted in the same SEND cycle go directly to GAP.
- A timeout and a y_tlast in the same cycle: the y_tlast wins and timeout_o stays low.

Other rules:
- Requesters must not deassert tvalid mid-packet. Withdrawal in SEND simply stalls; the grant is held.
- Reset mid-transaction returns the block to the reset state immediately. Partial packets are abandoned.

Test Plan:
1. Single request: s0 sends 3 bytes A5,5A,FF (tlast on FF), SPI loopback echoes 3 bytes with tlast. Expect grant_o=01 one cycle after s0_tvalid, x_tdata A5,5A,FF in order, m0 receives 3 bytes with tlast, grant_o=00 for GAP=4 cycles, then IDLE.
2. Contention: s0 and s1 both valid from reset. Expect order s0, s1, s0, s1 over 4 two-byte packets; grant_o is never 11; m1_tvalid is never high during an s0 transaction.
3. Back-pressure: x_tready toggles every cycle and m0_tready is low for 5 cycles mid-response. Expect no lost or duplicated bytes and the grant held throughout.
4. Timeout: TBITS=4, response stream held silent after request tlast. Expect timeout_o pulse exactly 15 cycles after WAIT entry. A late y beat afterwards is consumed with drop_o=1, and m0_tvalid stays 0.
5. Early response: y_tlast accepted in the same cycle as x_tlast. Expect a direct SEND to GAP transition, no WAIT cycle, and timeout_o=0.
6. Reset mid-SEND after 1 of 3 bytes. Expect grant_o=00, all treadys 0 the following cycle, and prio=0 so s0 wins the next contention.
